// File: rtl/voice_jbuf_pkg.sv
// Shared types and constants for the voice jitter-buffer controller.
package voice_jbuf_pkg;

    typedef enum logic {
        ST_PREFILL = 1'b0,
        ST_PLAY    = 1'b1
    } jbuf_state_t;

    localparam int STAT_W = 16;

    function automatic int jbuf_depth(input int asize);
        return 1 << asize;
    endfunction

endpackage

// File: rtl/voice_jbuf_stats.sv
// Two saturating event counters (underrun, overflow), cleared only by reset.
module voice_jbuf_stats
    import voice_jbuf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              underrun_evt,
    input  logic              overflow_evt,
    output logic [STAT_W-1:0] underrun_cnt,
    output logic [STAT_W-1:0] overflow_cnt
);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
            overflow_cnt <= '0;
        end else begin
            if (underrun_evt) underrun_cnt <= sat_inc(underrun_cnt);
            if (overflow_evt) overflow_cnt <= sat_inc(overflow_cnt);
        end
    end

endmodule

// File: rtl/voice_jbuf_ctrl.sv
// Jitter-buffer controller driving an external sync-write/async-read RAM as a ring.
// Optional statistics counters are built when VOICE_JBUF_STATS_EN is defined.
module voice_jbuf_ctrl
    import voice_jbuf_pkg::*;
#(
    parameter int ASIZE   = 13,
    parameter int DSIZE   = 8,
    parameter int PREFILL = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DSIZE-1:0]  i_wr_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DSIZE-1:0]  o_rd_data,
    output logic              o_ram_we,
    output logic [ASIZE-1:0]  o_ram_wr_addr,
    output logic [DSIZE-1:0]  o_ram_wr_data,
    output logic [ASIZE-1:0]  o_ram_rd_addr,
    input  logic [DSIZE-1:0]  i_ram_q,
    output logic [ASIZE:0]    o_count,
    output logic              o_playing,
    output logic              o_underrun,
    output logic [STAT_W-1:0] o_underrun_cnt,
    output logic [STAT_W-1:0] o_overflow_cnt
);

    localparam logic [ASIZE:0] DEPTH_C   = (ASIZE+1)'(jbuf_depth(ASIZE));
    localparam logic [ASIZE:0] PREFILL_C = (ASIZE+1)'(PREFILL);

    logic [ASIZE-1:0] wr_ptr;
    logic [ASIZE-1:0] rd_ptr;
    logic [ASIZE:0]   count;
    jbuf_state_t      state;
    jbuf_state_t      state_nxt;
    logic             underrun_nxt;
    logic             full;
    logic             empty;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign wr_fire = i_wr_valid & ~full & ~i_flush;
    assign rd_fire = o_rd_valid & i_rd_ready & ~i_flush;

    assign o_wr_ready    = ~full;
    assign o_rd_valid    = (state == ST_PLAY) & ~empty;
    assign o_rd_data     = i_ram_q;
    assign o_ram_we      = wr_fire;
    assign o_ram_wr_addr = wr_ptr;
    assign o_ram_wr_data = i_wr_data;
    assign o_ram_rd_addr = rd_ptr;
    assign o_count       = count;
    assign o_playing     = (state == ST_PLAY);

    // Pointers wrap naturally at ASIZE bits; count carries the extra bit for full.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_PREFILL;
            o_underrun <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_underrun <= underrun_nxt;
        end
    end

    // Threshold compares the registered count, so playout starts one cycle after it is met.
    always_comb begin
        state_nxt    = state;
        underrun_nxt = 1'b0;
        if (i_flush) begin
            state_nxt = ST_PREFILL;
        end else begin
            case (state)
                ST_PREFILL: if (count >= PREFILL_C) state_nxt = ST_PLAY;
                ST_PLAY: begin
                    if (empty && i_rd_ready) begin
                        state_nxt    = ST_PREFILL;
                        underrun_nxt = 1'b1;
                    end
                end
                default: state_nxt = ST_PREFILL;
            endcase
        end
    end

`ifdef VOICE_JBUF_STATS_EN
    logic overflow_evt;
    assign overflow_evt = i_wr_valid & full & ~i_flush;

    voice_jbuf_stats u_stats (
        .clk          (i_clk),
        .rst          (i_rst),
        .underrun_evt (underrun_nxt),
        .overflow_evt (overflow_evt),
        .underrun_cnt (o_underrun_cnt),
        .overflow_cnt (o_overflow_cnt)
    );
`else
    assign o_underrun_cnt = '0;
    assign o_overflow_cnt = '0;
`endif

endmodule

// File: tb/tb_voice_jbuf_ctrl.sv
// Randomized self-checking bench for voice_jbuf_ctrl against a queue-based model.
module tb_voice_jbuf_ctrl;

    localparam int ASIZE   = 3;
    localparam int DSIZE   = 8;
    localparam int PREFILL = 4;
    localparam int DEPTH   = 1 << ASIZE;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DSIZE-1:0]  wr_data = '0;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [DSIZE-1:0]  rd_data;
    logic              ram_we;
    logic [ASIZE-1:0]  ram_wr_addr;
    logic [DSIZE-1:0]  ram_wr_data;
    logic [ASIZE-1:0]  ram_rd_addr;
    logic [DSIZE-1:0]  ram_q;
    logic [ASIZE:0]    count;
    logic              playing;
    logic              underrun;
    logic [15:0]       underrun_cnt;
    logic [15:0]       overflow_cnt;

    logic [DSIZE-1:0]  mem [0:DEPTH-1];

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    assign ram_q = mem[ram_rd_addr];

    voice_jbuf_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE), .PREFILL(PREFILL)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_flush        (flush),
        .i_wr_valid     (wr_valid),
        .o_wr_ready     (wr_ready),
        .i_wr_data      (wr_data),
        .o_rd_valid     (rd_valid),
        .i_rd_ready     (rd_ready),
        .o_rd_data      (rd_data),
        .o_ram_we       (ram_we),
        .o_ram_wr_addr  (ram_wr_addr),
        .o_ram_wr_data  (ram_wr_data),
        .o_ram_rd_addr  (ram_rd_addr),
        .i_ram_q        (ram_q),
        .o_count        (count),
        .o_playing      (playing),
        .o_underrun     (underrun),
        .o_underrun_cnt (underrun_cnt),
        .o_overflow_cnt (overflow_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: samples in a queue, a playing flag, running totals.
    int q[$];
    bit m_playing;
    bit m_underrun;
    int m_ucnt, m_ocnt;
    int m_wr_idx, m_rd_idx;

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_clear();
        q.delete();
        m_playing = 0;
        m_wr_idx  = 0;
        m_rd_idx  = 0;
    endtask

    // One clock: drive at negedge, compare shortly after, advance model for the coming edge.
    task automatic step(input bit wv, input int wd, input bit rr, input bit fl);
        bit full_m, wfire, rvalid, rfire, und, ovf;
        @(negedge clk);
        wr_valid = wv;
        wr_data  = DSIZE'(wd);
        rd_ready = rr;
        flush    = fl;
        #1;
        full_m = (q.size() == DEPTH);
        rvalid = m_playing && (q.size() > 0);
        wfire  = wv && !full_m && !fl;
        rfire  = rvalid && rr && !fl;
        und    = m_playing && (q.size() == 0) && rr && !fl;
        ovf    = wv && full_m && !fl;

        chk("wr_ready", int'(wr_ready), int'(!full_m));
        chk("rd_valid", int'(rd_valid), int'(rvalid));
        chk("count", int'(count), q.size());
        chk("playing", int'(playing), int'(m_playing));
        chk("underrun", int'(underrun), int'(m_underrun));
        chk("ram_we", int'(ram_we), int'(wfire));
        chk("ram_wr_addr", int'(ram_wr_addr), m_wr_idx % DEPTH);
        chk("ram_rd_addr", int'(ram_rd_addr), m_rd_idx % DEPTH);
        if (rvalid) chk("rd_data", int'(rd_data), q[0]);
`ifdef VOICE_JBUF_STATS_EN
        chk("underrun_cnt", int'(underrun_cnt), m_ucnt);
        chk("overflow_cnt", int'(overflow_cnt), m_ocnt);
`else
        chk("underrun_cnt", int'(underrun_cnt), 0);
        chk("overflow_cnt", int'(overflow_cnt), 0);
`endif

        if (fl) begin
            model_clear();
            m_underrun = 0;
        end else begin
            if (!m_playing && q.size() >= PREFILL) m_playing = 1;
            else if (und) m_playing = 0;
            if (rfire) begin
                void'(q.pop_front());
                m_rd_idx++;
            end
            if (wfire) begin
                q.push_back(wd & 8'hFF);
                m_wr_idx++;
            end
            m_underrun = und;
            if (und) m_ucnt = sat16(m_ucnt);
            if (ovf) m_ocnt = sat16(m_ocnt);
        end
    endtask

    initial begin
        model_clear();
        m_underrun = 0;
        m_ucnt = 0;
        m_ocnt = 0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_underrun", int'(underrun), 0);

        // Prefill then play 0x10..0x13, ending in an underrun with ready held.
        for (int i = 0; i < 4; i++) step(1, 'h10 + i, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

        // Fill to full with the reader stalled, then one overflowing write.
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 'h20 + i, 0, 0);
        step(1, 'h99, 0, 0);
        step(0, 0, 0, 0);

        // Drain to 3, then simultaneous write/read across pointer wrap.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 'h40 + i, 1, 0);

        // Underrun, then resume after four writes.
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 'h60 + i, 0, 0);
        step(1, 'h64, 0, 0);
        step(0, 0, 0, 0);

        // Flush in PLAY at count=5 with a write offered; that write must not land.
        step(1, 'hEE, 0, 1);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 'h70 + i, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 55, int'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 63) == 0);

        // Overflow saturation: hold a full buffer under write pressure.
        step(0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0);
`ifdef VOICE_JBUF_STATS_EN
        for (int i = 0; i < 65540; i++) step(1, 'hAB, 0, 0);
        chk("ovf_saturated", int'(overflow_cnt), 65535);
`else
        for (int i = 0; i < 200; i++) step(1, 'hAB, 0, 0);
        chk("ovf_tied_zero", int'(overflow_cnt), 0);
`endif
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
